alu_issue_ctrl: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 51 +++++
 rtl/regfile_4x8.sv | 42 ++++
 rtl/alu_issue_ctrl.sv | 178 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_pkg
// Purpose  : Shared types and constants for the ALU issue controller:
//            instruction opcodes, ALU opcode encodings, controller states
//            and the bit positions of the instruction fields.
// Revision : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

  // Instruction opcodes, instr[15:13]
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_EOR = 3'b100,
    OP_MOV = 3'b101,
    OP_CMP = 3'b110,
    OP_ILL = 3'b111
  } op_e;

  // ALU opcodes the controller substitutes for MOV and CMP
  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_SUB = 3'b001;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_e;

  // Instruction field bit positions
  localparam int OP_MSB      = 15;
  localparam int OP_LSB      = 13;
  localparam int RD_MSB      = 12;
  localparam int RD_LSB      = 11;
  localparam int RS_MSB      = 10;
  localparam int RS_LSB      = 9;
  localparam int USE_IMM_BIT = 8;
  localparam int IMM_MSB     = 7;
  localparam int IMM_LSB     = 0;

  // Everything except CMP and the illegal opcode writes R[rd]
  function automatic logic op_writes_rd(input op_e op);
    return (op != OP_CMP) && (op != OP_ILL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_4x8.sv
`default_nettype none
// ============================================================================
// Module   : regfile_4x8
// Purpose  : Four 8-bit registers, three combinational read ports and one
//            synchronous write port, asynchronously cleared.
// Ports    : clk, rst            - clock, async active-high reset
//            we_i/waddr_i/wdata_i - write port
//            raddr_a_i/rdata_a_o  - operand A read port
//            raddr_b_i/rdata_b_o  - operand B read port
//            raddr_dbg_i/rdata_dbg_o - debug read port
// Revision : 1.0 - initial release
// ============================================================================
module regfile_4x8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  logic [1:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [1:0] raddr_a_i,
  input  logic [1:0] raddr_b_i,
  input  logic [1:0] raddr_dbg_i,
  output logic [7:0] rdata_a_o,
  output logic [7:0] rdata_b_o,
  output logic [7:0] rdata_dbg_o
);

  logic [3:0][7:0] regs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o   = regs_q[raddr_a_i];
  assign rdata_b_o   = regs_q[raddr_b_i];
  assign rdata_dbg_o = regs_q[raddr_dbg_i];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Three-phase (IDLE -> ISSUE -> WB) issue controller in front of
//            an external 8-bit ALU. Accepts an instruction, presents the
//            operands from a private 4x8 register file, captures the ALU
//            result/flags and retires the instruction in WB.
// Ports    : clk, rst                  - clock, async active-high reset
//            instr_valid/instr_ready   - instruction handshake
//            instr                     - {op, rd, rs, use_imm, imm}
//            alu_opcode/alu_a/alu_b    - registered ALU inputs
//            alu_result/alu_flag_z/_c  - ALU outputs (combinational)
//            done/illegal              - retire pulses
//            flag_z/flag_c             - architectural flags
//            dbg_sel/dbg_data          - debug register read
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [2:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_result,
  input  logic        alu_flag_z,
  input  logic        alu_flag_c,
  output logic        done,
  output logic        illegal,
  output logic        flag_z,
  output logic        flag_c,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  state_e     state_q;
  logic       ready_q;
  logic       done_q;
  logic       illegal_q;
  logic       flag_z_q;
  logic       flag_c_q;
  logic [2:0] alu_opcode_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;

  // Only op and rd are needed after acceptance; the operands themselves
  // are latched straight into alu_a_q/alu_b_q.
  op_e        op_q;
  logic [1:0] rd_q;

  // ALU outputs sampled at the end of ISSUE
  logic [7:0] res_q;
  logic       res_z_q;
  logic       res_c_q;

  logic       w_accept;
  op_e        w_op;
  logic [7:0] w_rd_data;
  logic [7:0] w_rs_data;
  logic [7:0] w_opnd_b;
  logic       w_we;

  assign w_accept = instr_valid && ready_q;
  assign w_op     = op_e'(instr[OP_MSB:OP_LSB]);
  assign w_opnd_b = instr[USE_IMM_BIT] ? instr[IMM_MSB:IMM_LSB] : w_rs_data;

  // The register file is written only at the end of WB, so operand reads
  // at acceptance always see the pre-instruction values (rd==rs is safe).
  assign w_we = (state_q == WB) && op_writes_rd(op_q);

  regfile_4x8 u_regfile (
    .clk         (clk),
    .rst         (rst),
    .we_i        (w_we),
    .waddr_i     (rd_q),
    .wdata_i     (res_q),
    .raddr_a_i   (instr[RD_MSB:RD_LSB]),
    .raddr_b_i   (instr[RS_MSB:RS_LSB]),
    .raddr_dbg_i (dbg_sel),
    .rdata_a_o   (w_rd_data),
    .rdata_b_o   (w_rs_data),
    .rdata_dbg_o (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_c_q     <= 1'b0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      op_q         <= OP_ADD;
      rd_q         <= '0;
      res_q        <= '0;
      res_z_q      <= 1'b0;
      res_c_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            state_q <= ISSUE;
            ready_q <= 1'b0;
            op_q    <= w_op;
            rd_q    <= instr[RD_MSB:RD_LSB];
            case (w_op)
              // MOV routes B through the adder with A forced to zero
              OP_MOV: begin
                alu_opcode_q <= ALU_OP_ADD;
                alu_a_q      <= '0;
                alu_b_q      <= w_opnd_b;
              end
              OP_CMP: begin
                alu_opcode_q <= ALU_OP_SUB;
                alu_a_q      <= w_rd_data;
                alu_b_q      <= w_opnd_b;
              end
              // Illegal ops leave the ALU inputs at their previous values
              OP_ILL: ;
              default: begin
                alu_opcode_q <= instr[OP_MSB:OP_LSB];
                alu_a_q      <= w_rd_data;
                alu_b_q      <= w_opnd_b;
              end
            endcase
          end else begin
            // Ready rises on the first edge after reset release
            ready_q <= 1'b1;
          end
        end
        ISSUE: begin
          state_q   <= WB;
          res_q     <= alu_result;
          res_z_q   <= alu_flag_z;
          res_c_q   <= alu_flag_c;
          done_q    <= 1'b1;
          illegal_q <= (op_q == OP_ILL);
        end
        WB: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          case (op_q)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_EOR, OP_CMP: begin
              flag_z_q <= res_z_q;
              flag_c_q <= res_c_q;
            end
            OP_MOV: flag_z_q <= (alu_b_q == 8'h00);
            default: ;
          endcase
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;
  assign alu_opcode  = alu_opcode_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Self-checking bench for alu_issue_ctrl. A stand-in ALU answers
//            the controller; an instruction-level model predicts every
//            output each cycle; directed sequences pin the model with
//            hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic        alu_flag_z;
  logic        alu_flag_c;
  logic        done;
  logic        illegal;
  logic        flag_z;
  logic        flag_c;
  logic [1:0]  dbg_sel = 2'd0;
  logic [7:0]  dbg_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ill_cnt = 0;
  int last_done_cyc = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_flag_z  (alu_flag_z),
    .alu_flag_c  (alu_flag_c),
    .done        (done),
    .illegal     (illegal),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  // Stand-in 8-bit ALU
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
    alu_result = 8'h00;
    alu_flag_c = 1'b0;
    case (alu_opcode)
      3'b000: begin alu_result = alu_sum[7:0]; alu_flag_c = alu_sum[8]; end
      3'b001: begin alu_result = alu_a - alu_b; alu_flag_c = (alu_a >= alu_b); end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      default: alu_result = 8'h00;
    endcase
    alu_flag_z = (alu_result == 8'h00);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  typedef struct packed {
    logic       wr;
    logic [1:0] rd;
    logic [7:0] val;
    logic       setz;
    logic       z;
    logic       setc;
    logic       c;
    logic       ill;
    logic       drive;
    logic [2:0] aop;
    logic [7:0] aa;
    logic [7:0] ab;
  } outcome_t;

  function automatic outcome_t predict(input logic [15:0] ins, input logic [3:0][7:0] regs);
    outcome_t   o;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         full;
    op = ins[15:13];
    a  = regs[ins[12:11]];
    b  = ins[8] ? ins[7:0] : regs[ins[10:9]];
    o       = '0;
    o.rd    = ins[12:11];
    o.aa    = a;
    o.ab    = b;
    o.aop   = op;
    o.drive = 1'b1;
    case (op)
      3'd0: begin full = int'(a) + int'(b); o.val = full[7:0]; o.c = (full > 255); end
      3'd1: begin o.val = a - b; o.c = (a >= b); end
      3'd2: o.val = a & b;
      3'd3: o.val = a | b;
      3'd4: o.val = a ^ b;
      3'd5: begin o.val = b; o.aop = 3'd0; o.aa = 8'h00; end
      3'd6: begin o.val = a - b; o.c = (a >= b); o.aop = 3'd1; end
      default: begin o.drive = 1'b0; o.ill = 1'b1; end
    endcase
    o.wr   = (op <= 3'd5);
    o.setz = (op != 3'd7);
    o.z    = (o.val == 8'h00);
    o.setc = (op <= 3'd4) || (op == 3'd6);
    return o;
  endfunction

  logic [3:0][7:0] m_reg;
  logic       m_z, m_c, m_ready, m_done, m_ill;
  logic [2:0] m_aop;
  logic [7:0] m_aa, m_ab;
  int         m_phase;
  outcome_t   pend;

  always @(posedge clk or posedge rst) begin : model
    outcome_t o;
    if (rst) begin
      m_reg <= '0; m_z <= 1'b0; m_c <= 1'b0; m_ready <= 1'b0;
      m_done <= 1'b0; m_ill <= 1'b0; m_aop <= '0; m_aa <= '0; m_ab <= '0;
      m_phase <= 0; pend <= '0;
    end else begin
      m_done <= 1'b0;
      m_ill  <= 1'b0;
      if (m_phase == 0) begin
        if (instr_valid && m_ready) begin
          o = predict(instr, m_reg);
          pend    <= o;
          m_ready <= 1'b0;
          m_phase <= 1;
          if (o.drive) begin m_aop <= o.aop; m_aa <= o.aa; m_ab <= o.ab; end
        end else begin
          m_ready <= 1'b1;
        end
      end else if (m_phase == 1) begin
        m_done  <= 1'b1;
        m_ill   <= pend.ill;
        m_phase <= 2;
      end else begin
        if (pend.wr)   m_reg[pend.rd] <= pend.val;
        if (pend.setz) m_z <= pend.z;
        if (pend.setc) m_c <= pend.c;
        m_ready <= 1'b1;
        m_phase <= 0;
      end
    end
  end

  // Per-cycle compare, mid-cycle; rotates the debug select
  always @(negedge clk) begin
    chk("instr_ready", {7'd0, instr_ready}, {7'd0, m_ready});
    chk("done", {7'd0, done}, {7'd0, m_done});
    chk("illegal", {7'd0, illegal}, {7'd0, m_ill});
    chk("flag_z", {7'd0, flag_z}, {7'd0, m_z});
    chk("flag_c", {7'd0, flag_c}, {7'd0, m_c});
    chk("alu_opcode", {5'd0, alu_opcode}, {5'd0, m_aop});
    chk("alu_a", alu_a, m_aa);
    chk("alu_b", alu_b, m_ab);
    chk("dbg_data", dbg_data, m_reg[dbg_sel]);
    if (done) begin done_cnt++; last_done_cyc = cyc; end
    if (illegal) ill_cnt++;
    dbg_sel = dbg_sel + 2'd1;
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic ui, input logic [7:0] imm, input bit keep, output int acc);
    int t;
    t = 0;
    acc = -1;
    instr = {op, rd, rs, ui, imm};
    instr_valid = 1'b1;
    @(negedge clk);
    while (!instr_ready && t < 20) begin @(negedge clk); t++; end
    if (!instr_ready) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: instr_ready stayed 0, expected 1");
    end else begin
      acc = cyc;
      @(posedge clk); #1;
    end
    if (!keep) instr_valid = 1'b0;
  endtask

  task automatic retire();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int a0, a1, a2, a3;
    int dc;
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    chk("ready_during_release", {7'd0, instr_ready}, 8'd0);
    @(posedge clk); #1;
    chk("ready_after_release", {7'd0, instr_ready}, 8'd1);

    // MOV R1,#FF ; ADD R1,#01
    issue(3'd5, 2'd1, 2'd0, 1'b1, 8'hFF, 1'b0, a0); retire();
    chk("mov_done_delay", 8'(last_done_cyc - a0), 8'd2);
    issue(3'd0, 2'd1, 2'd0, 1'b1, 8'h01, 1'b0, a0); retire();
    chk("add_done_delay", 8'(last_done_cyc - a0), 8'd2);
    chk("add_done_cnt", 8'(done_cnt), 8'd2);
    chk("add_R1", m_reg[1], 8'h00);
    chk("add_Z", {7'd0, flag_z}, 8'd1);
    chk("add_C", {7'd0, flag_c}, 8'd1);

    // R2=3 ; SUB R2,#5 ; CMP R2,#FE
    issue(3'd5, 2'd2, 2'd0, 1'b1, 8'h03, 1'b0, a0); retire();
    issue(3'd1, 2'd2, 2'd0, 1'b1, 8'h05, 1'b0, a0); retire();
    chk("sub_R2", m_reg[2], 8'hFE);
    chk("sub_Z", {7'd0, flag_z}, 8'd0);
    chk("sub_C", {7'd0, flag_c}, 8'd0);
    issue(3'd6, 2'd2, 2'd0, 1'b1, 8'hFE, 1'b0, a0); retire();
    chk("cmp_R2", m_reg[2], 8'hFE);
    chk("cmp_Z", {7'd0, flag_z}, 8'd1);
    chk("cmp_C", {7'd0, flag_c}, 8'd1);

    // AND R1,R1 with R1=0, C=1 beforehand
    issue(3'd2, 2'd1, 2'd1, 1'b0, 8'h00, 1'b0, a0); retire();
    chk("and_Z", {7'd0, flag_z}, 8'd1);
    chk("and_C", {7'd0, flag_c}, 8'd0);

    // MOV R3,#5A then illegal with rd=3
    issue(3'd5, 2'd3, 2'd0, 1'b1, 8'h5A, 1'b0, a0); retire();
    issue(3'd7, 2'd3, 2'd0, 1'b1, 8'h11, 1'b0, a0); retire();
    chk("ill_cnt", 8'(ill_cnt), 8'd1);
    chk("ill_R3", m_reg[3], 8'h5A);
    chk("ill_Z", {7'd0, flag_z}, 8'd0);
    chk("ill_C", {7'd0, flag_c}, 8'd0);

    // Three ADD R0,#1 back to back with valid held high
    issue(3'd0, 2'd0, 2'd0, 1'b1, 8'h01, 1'b1, a0);
    issue(3'd0, 2'd0, 2'd0, 1'b1, 8'h01, 1'b1, a1);
    issue(3'd0, 2'd0, 2'd0, 1'b1, 8'h01, 1'b0, a2);
    retire();
    chk("b2b_gap1", 8'(a1 - a0), 8'd3);
    chk("b2b_gap2", 8'(a2 - a1), 8'd3);
    chk("b2b_R0", m_reg[0], 8'h03);

    // Fourth ADD killed by reset during ISSUE
    dc = done_cnt;
    issue(3'd0, 2'd0, 2'd0, 1'b1, 8'h01, 1'b0, a3);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_no_done", 8'(done_cnt - dc), 8'd0);
    chk("rst_R0", m_reg[0], 8'h00);
    @(posedge clk); #1;
    chk("rst_ready", {7'd0, instr_ready}, 8'd1);

    // Controller still functional after reset
    issue(3'd4, 2'd0, 2'd0, 1'b1, 8'h0F, 1'b0, a0); retire();
    chk("eor_R0", m_reg[0], 8'h0F);
    repeat (4) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
